bren_line: RTL and testbench

Bresenham line engine. It is the responder to the missile controller's `bren_go` / `xflying_end` / `yflying_end` request. On a `bren_go` request it latches a launch origin and an end point, then walks the missile position one pixel per step along the Bresenham line. It reports `valid_drawing` while the position is live and `bren_done` once the end point is reached. Its `xflying` / `yflying` outputs feed the missile hit/out-of-frame checks and the vector renderer.

---
 rtl/vector_pkg.sv | 14 +
 rtl/bren_tick.sv | 26 ++
 rtl/bren_line.sv | 114 +++++++++++
 tb/tb_bren_line.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared types and constants for the vector/missile line-drawing blocks.
package vector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } bren_state_t;

  // Default pixel-step divider, also used by the missile controller.
  localparam int BREN_STEP_DIV = 4;

endpackage

// File: rtl/bren_tick.sv
// Step-rate divider: one-cycle tick every STEP_DIV enabled cycles, clearable.
module bren_tick #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(STEP_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/bren_line.sv
// Bresenham line engine: walks (xflying,yflying) from a latched origin to a
// latched end point, one pixel per STEP_DIV cycles, while bren_go is held.
module bren_line
  import vector_pkg::*;
#(
  parameter int OUT_WIDTH = 8,
  parameter int STEP_DIV  = BREN_STEP_DIV
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bren_go,
  input  logic [OUT_WIDTH-1:0] xorigin,
  input  logic [OUT_WIDTH-1:0] yorigin,
  input  logic [OUT_WIDTH-1:0] xflying_end,
  input  logic [OUT_WIDTH-1:0] yflying_end,
  output logic [OUT_WIDTH-1:0] xflying,
  output logic [OUT_WIDTH-1:0] yflying,
  output logic                 valid_drawing,
  output logic                 bren_done
);

  localparam int W = OUT_WIDTH;

  bren_state_t state;

  logic [W-1:0]        x0, y0, x1, y1;
  logic signed [W:0]   dx, dy;
  logic signed [W+1:0] err;
  logic                sx_neg, sy_neg;

  logic [W-1:0]        adx, ady;
  logic signed [W:0]   dx_l, dy_l;
  logic signed [W+1:0] err_l, dx_w, dy_w, e2, inc_x, inc_y, err_nxt;
  logic                step_x, step_y, at_end, tick;

  bren_tick #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != DRAW),
    .en   (state == DRAW),
    .tick (tick)
  );

  always_comb begin
    // Setup terms from the latched endpoints, consumed in LOAD.
    adx     = (x1 >= x0) ? x1 - x0 : x0 - x1;
    ady     = (y1 >= y0) ? y1 - y0 : y0 - y1;
    dx_l    = $signed({1'b0, adx});
    dy_l    = -$signed({1'b0, ady});
    err_l   = dx_l + dy_l;
    // Step decision; both axis updates share the same e2.
    dx_w    = dx;
    dy_w    = dy;
    e2      = err <<< 1;
    step_x  = (e2 >= dy_w);
    step_y  = (e2 <= dx_w);
    inc_x   = step_x ? dy_w : '0;
    inc_y   = step_y ? dx_w : '0;
    err_nxt = err + inc_x + inc_y;
    at_end  = (xflying == x1) && (yflying == y1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      xflying       <= '0;
      yflying       <= '0;
      valid_drawing <= 1'b0;
      bren_done     <= 1'b0;
    end else if (state != IDLE && !bren_go) begin
      // Abort: position holds its last value, flags drop.
      state         <= IDLE;
      valid_drawing <= 1'b0;
      bren_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bren_go) begin
            x0    <= xorigin;
            y0    <= yorigin;
            x1    <= xflying_end;
            y1    <= yflying_end;
            state <= LOAD;
          end
        end
        LOAD: begin
          dx            <= dx_l;
          dy            <= dy_l;
          err           <= err_l;
          sx_neg        <= (x1 < x0);
          sy_neg        <= (y1 < y0);
          xflying       <= x0;
          yflying       <= y0;
          valid_drawing <= 1'b1;
          state         <= DRAW;
        end
        DRAW: begin
          if (tick) begin
            if (at_end) begin
              bren_done <= 1'b1;
              state     <= DONE;
            end else begin
              err <= err_nxt;
              if (step_x) xflying <= sx_neg ? xflying - 1'b1 : xflying + 1'b1;
              if (step_y) yflying <= sy_neg ? yflying - 1'b1 : yflying + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bren_line.sv
// Self-checking bench for bren_line: three instances (STEP_DIV 1/2/4) share
// stimulus and are compared each cycle against a timing-rule reference model.
module tb_bren_line;

  localparam int SD[3] = '{1, 2, 4};

  logic       clk = 1'b0;
  logic       rst;
  logic       bren_go;
  logic [7:0] xorigin, yorigin, xflying_end, yflying_end;
  logic [7:0] xo[3], yo[3];
  logic       vo[3], dn[3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bren_line #(.OUT_WIDTH(8), .STEP_DIV(1)) u_s1 (
    .clk(clk), .rst(rst), .bren_go(bren_go), .xorigin(xorigin), .yorigin(yorigin),
    .xflying_end(xflying_end), .yflying_end(yflying_end),
    .xflying(xo[0]), .yflying(yo[0]), .valid_drawing(vo[0]), .bren_done(dn[0]));
  bren_line #(.OUT_WIDTH(8), .STEP_DIV(2)) u_s2 (
    .clk(clk), .rst(rst), .bren_go(bren_go), .xorigin(xorigin), .yorigin(yorigin),
    .xflying_end(xflying_end), .yflying_end(yflying_end),
    .xflying(xo[1]), .yflying(yo[1]), .valid_drawing(vo[1]), .bren_done(dn[1]));
  bren_line #(.OUT_WIDTH(8), .STEP_DIV(4)) u_s4 (
    .clk(clk), .rst(rst), .bren_go(bren_go), .xorigin(xorigin), .yorigin(yorigin),
    .xflying_end(xflying_end), .yflying_end(yflying_end),
    .xflying(xo[2]), .yflying(yo[2]), .valid_drawing(vo[2]), .bren_done(dn[2]));

  // Reference model: a flight is a precomputed pixel path; outputs follow the
  // timing rules (origin at cycle 2, step k at 2+kS, done at 2+(N+1)S).
  int         px[$], py[$];
  logic [7:0] mx[3], my[3];
  logic       mv[3], md[3];
  bit         act = 0;
  int         cyc = 0, t0 = 0;
  int         bx, by, bx1, by1, bdx, bdy, bsx, bsy, berr, be2, r, k, n;

  always @(posedge clk) begin
    if (rst) begin
      act = 0;
      for (int d = 0; d < 3; d++) begin mx[d] = 0; my[d] = 0; mv[d] = 0; md[d] = 0; end
    end else if (!act) begin
      if (bren_go) begin
        act = 1; t0 = cyc;
        px.delete(); py.delete();
        bx = xorigin; by = yorigin; bx1 = xflying_end; by1 = yflying_end;
        bdx = (bx1 > bx) ? bx1 - bx : bx - bx1;
        bdy = -((by1 > by) ? by1 - by : by - by1);
        bsx = (bx < bx1) ? 1 : -1;
        bsy = (by < by1) ? 1 : -1;
        berr = bdx + bdy;
        for (int g = 0; g < 600; g++) begin
          px.push_back(bx); py.push_back(by);
          if (bx == bx1 && by == by1) break;
          be2 = 2 * berr;
          if (be2 >= bdy) begin berr += bdy; bx += bsx; end
          if (be2 <= bdx) begin berr += bdx; by += bsy; end
        end
      end
    end else if (!bren_go) begin
      act = 0;
      for (int d = 0; d < 3; d++) begin mv[d] = 0; md[d] = 0; end
    end else begin
      r = cyc + 1 - t0;
      n = px.size() - 1;
      if (r >= 2)
        for (int d = 0; d < 3; d++) begin
          k = (r - 2) / SD[d];
          mv[d] = 1;
          md[d] = (k > n);
          if (k > n) k = n;
          mx[d] = 8'(px[k]);
          my[d] = 8'(py[k]);
        end
    end
    cyc++;
  end

  function automatic logic [17:0] expv(int d);
    return {mx[d], my[d], mv[d], md[d]};
  endfunction

  function automatic logic [17:0] obsv(int d);
    return {xo[d], yo[d], vo[d], dn[d]};
  endfunction

  task automatic launch(input int x0, input int y0, input int x1, input int y1);
    xorigin = 8'(x0); yorigin = 8'(y0); xflying_end = 8'(x1); yflying_end = 8'(y1);
    bren_go = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bren_go = 1'b0;
    launch(0, 0, 0, 0); bren_go = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obsv(d) !== 18'h0) begin
        errors++; $display("FAIL reset S=%0d got %h want %h", SD[d], obsv(d), 18'h0);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_horizontal();
    int done_at = -1;
    launch(10, 10, 20, 10);
    for (int rel = 1; rel <= 60; rel++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obsv(d) !== expv(d)) begin
          errors++; $display("FAIL horiz S=%0d t=%0d got %h want %h", SD[d], rel, obsv(d), expv(d));
        end
      end
      if (dn[0] === 1'b1 && done_at < 0) done_at = rel;
    end
    checks++;
    if (done_at != 13) begin errors++; $display("FAIL horiz_done got %0d want 13", done_at); end
    bren_go = 1'b0; repeat (2) @(negedge clk);
  endtask

  task automatic test_steep();
    int done_at = -1;
    int qx[$], qy[$];
    int ex[7] = '{50, 50, 51, 51, 51, 52, 52};
    int ey[7] = '{50, 51, 52, 53, 54, 55, 56};
    launch(50, 50, 52, 56);
    for (int rel = 1; rel <= 40; rel++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obsv(d) !== expv(d)) begin
          errors++; $display("FAIL steep S=%0d t=%0d got %h want %h", SD[d], rel, obsv(d), expv(d));
        end
      end
      if (vo[0] === 1'b1 && (qx.size() == 0 || qx[$] != xo[0] || qy[$] != yo[0])) begin
        qx.push_back(xo[0]); qy.push_back(yo[0]);
      end
      if (dn[0] === 1'b1 && done_at < 0) done_at = rel;
    end
    checks++;
    if (qx.size() != 7) begin errors++; $display("FAIL steep_len got %0d want 7", qx.size()); end
    else
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (qx[i] != ex[i] || qy[i] != ey[i]) begin
          errors++; $display("FAIL steep_pt%0d got (%0d,%0d) want (%0d,%0d)", i, qx[i], qy[i], ex[i], ey[i]);
        end
      end
    checks++;
    if (done_at != 9) begin errors++; $display("FAIL steep_done got %0d want 9", done_at); end
    bren_go = 1'b0; repeat (2) @(negedge clk);
  endtask

  task automatic test_negative();
    int done_at = -1;
    launch(100, 200, 103, 197);
    for (int rel = 1; rel <= 30; rel++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obsv(d) !== expv(d)) begin
          errors++; $display("FAIL neg S=%0d t=%0d got %h want %h", SD[d], rel, obsv(d), expv(d));
        end
      end
      if (rel == 9) begin
        checks++;
        if (xo[2] !== 8'd101 || yo[2] !== 8'd199) begin
          errors++; $display("FAIL neg_hold got (%0d,%0d) want (101,199)", xo[2], yo[2]);
        end
      end
      if (dn[2] === 1'b1 && done_at < 0) done_at = rel;
    end
    checks++;
    if (done_at != 18) begin errors++; $display("FAIL neg_done got %0d want 18", done_at); end
    bren_go = 1'b0; repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    launch(0, 0, 30, 0);
    for (int rel = 1; rel <= 40; rel++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obsv(d) !== expv(d)) begin
          errors++; $display("FAIL abort S=%0d t=%0d got %h want %h", SD[d], rel, obsv(d), expv(d));
        end
      end
      if (rel == 7) begin
        checks++;
        if ({xo[0], vo[0], dn[0]} !== {8'd4, 2'b00}) begin
          errors++; $display("FAIL abort_hold got x=%0d v=%b d=%b want x=4 v=0 d=0", xo[0], vo[0], dn[0]);
        end
      end
      if (rel == 11) begin
        checks++;
        if ({xo[0], yo[0], vo[0]} !== {8'd0, 8'd0, 1'b1}) begin
          errors++; $display("FAIL abort_restart got (%0d,%0d) v=%b want (0,0) v=1", xo[0], yo[0], vo[0]);
        end
      end
      if (rel == 6) bren_go = 1'b0;
      if (rel == 9) begin xflying_end = 8'd5; bren_go = 1'b1; end
    end
    bren_go = 1'b0; repeat (2) @(negedge clk);
  endtask

  task automatic test_frozen_zero();
    int done_at[3] = '{-1, -1, -1};
    launch(60, 60, 70, 65);
    for (int rel = 1; rel <= 60; rel++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obsv(d) !== expv(d)) begin
          errors++; $display("FAIL frozen S=%0d t=%0d got %h want %h", SD[d], rel, obsv(d), expv(d));
        end
      end
      if (rel == 4) begin xflying_end = 8'd90; yflying_end = 8'd0; xorigin = 8'd3; end
    end
    checks++;
    if ({xo[2], yo[2], dn[2]} !== {8'd70, 8'd65, 1'b1}) begin
      errors++; $display("FAIL frozen_end got (%0d,%0d) d=%b want (70,65) d=1", xo[2], yo[2], dn[2]);
    end
    bren_go = 1'b0; repeat (2) @(negedge clk);
    launch(40, 40, 40, 40);
    for (int rel = 1; rel <= 12; rel++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obsv(d) !== expv(d)) begin
          errors++; $display("FAIL zero S=%0d t=%0d got %h want %h", SD[d], rel, obsv(d), expv(d));
        end
        if (dn[d] === 1'b1 && done_at[d] < 0) done_at[d] = rel;
      end
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (done_at[d] != 2 + SD[d]) begin
        errors++; $display("FAIL zero_done S=%0d got %0d want %0d", SD[d], done_at[d], 2 + SD[d]);
      end
    end
    bren_go = 1'b0; repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    launch(5, 5, 60, 30);
    for (int rel = 1; rel <= 24; rel++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obsv(d) !== expv(d)) begin
          errors++; $display("FAIL rstmid S=%0d t=%0d got %h want %h", SD[d], rel, obsv(d), expv(d));
        end
        if (rel == 11) begin
          checks++;
          if (obsv(d) !== 18'h0) begin
            errors++; $display("FAIL rstmid_zero S=%0d got %h want %h", SD[d], obsv(d), 18'h0);
          end
        end
      end
      if (rel == 13) begin
        checks++;
        if ({xo[0], yo[0], vo[0]} !== {8'd5, 8'd5, 1'b1}) begin
          errors++; $display("FAIL rstmid_relaunch got (%0d,%0d) v=%b want (5,5) v=1", xo[0], yo[0], vo[0]);
        end
      end
      if (rel == 10) rst = 1'b1;
      if (rel == 11) rst = 1'b0;
    end
    bren_go = 1'b0; repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int x0 = $urandom_range(0, 255);
      int y0 = $urandom_range(0, 255);
      int x1 = x0 + $urandom_range(0, 40) - 20;
      int y1 = y0 + $urandom_range(0, 40) - 20;
      int abort_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : -1;
      if (x1 < 0) x1 = 0; if (x1 > 255) x1 = 255;
      if (y1 < 0) y1 = 0; if (y1 > 255) y1 = 255;
      launch(x0, y0, x1, y1);
      for (int rel = 1; rel <= 100; rel++) begin
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
          checks++;
          if (obsv(d) !== expv(d)) begin
            errors++; $display("FAIL rand%0d S=%0d t=%0d got %h want %h", f, SD[d], rel, obsv(d), expv(d));
          end
        end
        if (rel == 5) begin xflying_end = 8'($urandom); yorigin = 8'($urandom); end
        if (rel == abort_at) bren_go = 1'b0;
        if (abort_at > 0 && rel == abort_at + 1) bren_go = 1'($urandom_range(0, 1));
      end
      bren_go = 1'b0; repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; bren_go = 1'b0;
    xorigin = '0; yorigin = '0; xflying_end = '0; yflying_end = '0;
    test_reset();
    test_horizontal();
    test_steep();
    test_negative();
    test_abort();
    test_frozen_zero();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
